// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: serves LW/SW from a
// word-addressed array after LATENCY busy cycles. Optional counters: DMEM_STATS_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_stall,
  output logic        mem_fault
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_stall_cycles
`endif
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  stall_c;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req, access, misalign, do_read, do_write;
  logic                  unused_addr;

  assign req         = mem_ren | mem_wen;
  assign idx         = mem_addr[ADDR_WIDTH+1:2];
  assign misalign    = (mem_addr[1:0] != 2'b00);
  assign access      = (state == BUSY) && (cnt == '0);
  // write wins when both enables are set; misaligned stores never reach the array
  assign do_read     = access & mem_ren & ~mem_wen;
  assign do_write    = access & mem_wen & ~misalign;
  assign unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    case (state)
      IDLE: if (req) begin
        stall_c   = 1'b1;
        cnt_nxt   = CW'(LATENCY - 1);
        state_nxt = BUSY;
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
        else           state_nxt = DONE;
      end
      DONE: if (mem_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stall must drop the instant reset asserts, even with a request still held
  assign mem_stall = stall_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_dout  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_read) mem_dout <= mem[idx];
      if (access)  mem_fault <= misalign | (mem_ren & mem_wen);
    end
  end

  // array contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= mem_din;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads        <= '0;
      stat_writes       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (do_read)           stat_reads        <= stat_reads + 32'd1;
      if (access && mem_wen) stat_writes       <= stat_writes + 32'd1;
      if (mem_stall)         stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
